// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned 32x32 multiply / 32/32 divide sequencer that borrows the
// shared ripple ALU for one add/subtract per clock while busy.
module alu_muldiv_seq #(
  parameter logic [2:0] ADD_OP = 3'b010,
  parameter logic [2:0] SUB_OP = 3'b110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_r,
  input  logic        alu_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        op_q;
  logic [31:0] opnd_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_d, lo_d;
  logic [4:0]  cnt_q;
  logic        dbz_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] div_t;
  logic        div_q;

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

  // ALU drive depends on registered state only; inputs never reach the ALU directly.
  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = ADD_OP;
    hi_d   = hi_q;
    lo_d   = lo_q;
    div_t  = {hi_q[30:0], lo_q[31]};
    div_q  = hi_q[31] | alu_c;
    if (state_q == S_RUN) begin
      if (!op_q) begin
        alu_a = hi_q;
        alu_b = lo_q[0] ? opnd_q : 32'd0;
        hi_d  = {alu_c, alu_r[31:1]};
        lo_d  = {alu_r[0], lo_q[31:1]};
      end else begin
        // hi_q[31] set means the 33-bit partial remainder already exceeds any divisor
        alu_op = SUB_OP;
        alu_a  = div_t;
        alu_b  = opnd_q;
        hi_d   = div_q ? alu_r : div_t;
        lo_d   = {lo_q[30:0], div_q};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      opnd_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt_q   <= 5'd0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            opnd_q <= b_in;
            cnt_q  <= 5'd0;
            busy_q <= 1'b1;
            if (op && (b_in == 32'd0)) begin
              hi_q    <= a_in;
              lo_q    <= 32'hFFFF_FFFF;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              hi_q    <= 32'd0;
              lo_q    <= a_in;
              dbz_q   <= 1'b0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
